// File: rtl/datamem_hs_if.sv
// Request/response bundle between the core's MEM stage and datamem_hs.
// The core drives the master side; the memory implements the slave side.
interface datamem_hs_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/datamem_hs.sv
// Big-endian byte-addressable data memory with a valid/ready request port,
// programmable read latency and alignment/range fault reporting.
module datamem_hs #(
    parameter logic [31:0] STARTADDR  = 32'h1000_0000,
    parameter logic [31:0] LENGTH     = 32'h0000_1000,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    datamem_hs_if.slave bus
);
    localparam int          AW      = $clog2(LENGTH);
    localparam logic [32:0] FIRST33 = {1'b0, STARTADDR};
    localparam logic [32:0] LAST33  = {1'b0, STARTADDR} + {1'b0, LENGTH} - 33'd1;
    localparam logic [3:0]  LAT_M1  = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;

    logic [7:0]    mem [LENGTH];
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [32:0]   nbytes33, last_byte33;
    logic          req_fault, accept;
    logic [31:0]   ld_data;
    logic [7:0]    b0, b1, b2, b3;

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    // Offset into the array; bits above AW are dropped because out-of-range accesses fault anyway.
    assign idx0 = AW'(bus.req_addr - STARTADDR);
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        nbytes33 = 33'd4;
        case (bus.req_size)
            2'b00:   nbytes33 = 33'd1;
            2'b01:   nbytes33 = 33'd2;
            default: nbytes33 = 33'd4;
        endcase
        last_byte33 = {1'b0, bus.req_addr} + nbytes33 - 33'd1;
        req_fault   = (bus.req_size == 2'b11)
                   || (bus.req_size == 2'b01 && bus.req_addr[0])
                   || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                   || ({1'b0, bus.req_addr} < FIRST33)
                   || (last_byte33 > LAST33);
    end

    assign b0 = mem[idx0];
    assign b1 = mem[idx1];
    assign b2 = mem[idx2];
    assign b3 = mem[idx3];

    always_comb begin
        ld_data = {b0, b1, b2, b3};
        case (bus.req_size)
            2'b00:   ld_data = bus.req_unsigned ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   ld_data = bus.req_unsigned ? {16'h0, b0, b1} : {{16{b0[7]}}, b0, b1};
            default: ld_data = {b0, b1, b2, b3};
        endcase
    end

    // NOTE: the array has no reset; its contents survive reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_fault) begin
            case (bus.req_size)
                2'b00: mem[idx0] <= bus.req_wdata[7:0];
                2'b01: begin
                    mem[idx0] <= bus.req_wdata[15:8];
                    mem[idx1] <= bus.req_wdata[7:0];
                end
                default: begin
                    mem[idx0] <= bus.req_wdata[31:24];
                    mem[idx1] <= bus.req_wdata[23:16];
                    mem[idx2] <= bus.req_wdata[15:8];
                    mem[idx3] <= bus.req_wdata[7:0];
                end
            endcase
        end
    end

    // cnt_q counts cycles since accept, the accept cycle itself being 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    fault_d = req_fault;
                    data_d  = (req_fault || bus.req_we) ? 32'h0 : ld_data;
                    cnt_d   = 4'd1;
                    state_d = (RD_LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT_M1) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                data_d  = 32'h0;
                fault_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = (state_q == RESP) ? data_q : 32'h0;
    assign bus.resp_fault = (state_q == RESP) && fault_q;
endmodule
